// File: rtl/game_ctrl_pkg.sv
// Shared game-sequencer types and constants.
package game_ctrl_pkg;

  // Encoding is fixed: car_ctrl compares game_state against 2'b01 for RUNNING.
  typedef enum logic [1:0] {
    GS_IDLE      = 2'b00,
    GS_RUNNING   = 2'b01,
    GS_GAME_OVER = 2'b10,
    GS_PAUSE     = 2'b11
  } game_state_t;

  localparam int GAME_MAX_LEVEL  = 9;
  localparam int GAME_LIVES_INIT = 3;

  // Everything the sequencer registers apart from the pause counter and lives.
  typedef struct packed {
    game_state_t state;
    logic [3:0]  level;
    logic        round_reset;
    logic        win;
    logic        pend_lvl;
  } game_regs_t;

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector: one register plus an AND. RST_VAL sets the
// "previous" value seen out of reset, so 1 suppresses an edge for an
// input already held high through reset.
module rise_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_D,
  output logic o_Rise
);

  logic r_prev;

  // Remember last cycle's input.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_prev <= RST_VAL;
    else         r_prev <= i_D;
  end

  assign o_Rise = i_D & ~r_prev;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: IDLE/RUNNING/PAUSE/GAME_OVER FSM driving level, lives and
// the round-reset pulse fanned out to every car_ctrl.
// Optional lives counter: define GAME_LIVES_EN to enable it; otherwise any
// collision ends the game and o_lives reads 1.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int PAUSE_CYCLES = 25_000_000,
  parameter int MAX_LEVEL    = GAME_MAX_LEVEL,
  parameter int LIVES_INIT   = GAME_LIVES_INIT
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic       i_Collision,
  input  logic       i_Goal,
  output logic [1:0] o_game_state,
  output logic [3:0] o_level,
  output logic [1:0] o_lives,
  output logic       o_round_reset,
  output logic       o_win
);

  localparam int              CNT_W     = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [3:0]      LVL_MAX   = 4'(MAX_LEVEL);
  localparam logic [1:0]      LIVES_RST = 2'(LIVES_INIT);

  logic w_start_edge;

  rise_edge #(.RST_VAL(1'b1)) u_start_edge (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_D     (i_Start),
    .o_Rise  (w_start_edge)
  );

  game_regs_t       r_q, w_d;
  logic [CNT_W-1:0] r_pause_cnt, w_pause_cnt;

`ifdef GAME_LIVES_EN
  logic [1:0] r_lives, w_lives;

  // Lives counter.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_lives <= LIVES_RST;
    else         r_lives <= w_lives;
  end

  assign o_lives = r_lives;
`else
  // LIVES_INIT has no effect without the lives counter.
  logic w_unused_lives_init;
  assign w_unused_lives_init = ^LIVES_RST;
  assign o_lives = 2'd1;
`endif

  // State, level, flags and pause counter.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_q.state       <= GS_IDLE;
      r_q.level       <= 4'd1;
      r_q.round_reset <= 1'b0;
      r_q.win         <= 1'b0;
      r_q.pend_lvl    <= 1'b0;
      r_pause_cnt     <= '0;
    end else begin
      r_q         <= w_d;
      r_pause_cnt <= w_pause_cnt;
    end
  end

  // Next-state logic; round_reset defaults low so it is a single-cycle pulse.
  always_comb begin
    w_d             = r_q;
    w_d.round_reset = 1'b0;
    w_pause_cnt     = r_pause_cnt;
`ifdef GAME_LIVES_EN
    w_lives         = r_lives;
`endif
    case (r_q.state)
      GS_IDLE, GS_GAME_OVER: begin
        if (w_start_edge) begin
          w_d.state       = GS_RUNNING;
          w_d.level       = 4'd1;
          w_d.win         = 1'b0;
          w_d.round_reset = 1'b1;
          w_d.pend_lvl    = 1'b0;
`ifdef GAME_LIVES_EN
          w_lives         = LIVES_RST;
`endif
        end
      end
      GS_RUNNING: begin
        // First cycle of a round: cars are still at stale positions.
        if (!r_q.round_reset) begin
          if (i_Collision) begin
`ifdef GAME_LIVES_EN
            if (r_lives > 2'd1) begin
              w_lives      = r_lives - 2'd1;
              w_d.state    = GS_PAUSE;
              w_d.pend_lvl = 1'b0;
            end else begin
              w_lives   = 2'd0;
              w_d.state = GS_GAME_OVER;
              w_d.win   = 1'b0;
            end
`else
            w_d.state = GS_GAME_OVER;
            w_d.win   = 1'b0;
`endif
          end else if (i_Goal) begin
            if (r_q.level < LVL_MAX) begin
              w_d.state    = GS_PAUSE;
              w_d.pend_lvl = 1'b1;
            end else begin
              w_d.state = GS_GAME_OVER;
              w_d.win   = 1'b1;
            end
          end
        end
      end
      GS_PAUSE: begin
        if (r_pause_cnt == CNT_LAST) begin
          w_pause_cnt     = '0;
          w_d.state       = GS_RUNNING;
          w_d.round_reset = 1'b1;
          if (r_q.pend_lvl && (r_q.level < LVL_MAX)) w_d.level = r_q.level + 4'd1;
          w_d.pend_lvl    = 1'b0;
        end else begin
          w_pause_cnt = r_pause_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_game_state  = r_q.state;
  assign o_level       = r_q.level;
  assign o_round_reset = r_q.round_reset;
  assign o_win         = r_q.win;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with PAUSE_CYCLES=4 and MAX_LEVEL=9.
// Each step drives inputs, takes one clock edge and checks outputs 1 ns later.
module tb_game_ctrl;

  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_GO = 2'b10, S_PAU = 2'b11;
`ifdef GAME_LIVES_EN
  localparam logic [1:0] LV3 = 2'd3;
`else
  localparam logic [1:0] LV3 = 2'd1;
`endif

  logic       clk = 1'b0;
  logic       rst, start, coll, goal;
  logic [1:0] state, lives;
  logic [3:0] level;
  logic       rr, win;

  int errors = 0;
  int checks = 0;

  game_ctrl #(.PAUSE_CYCLES(4), .MAX_LEVEL(9), .LIVES_INIT(3)) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Start       (start),
    .i_Collision   (coll),
    .i_Goal        (goal),
    .o_game_state  (state),
    .o_level       (level),
    .o_lives       (lives),
    .o_round_reset (rr),
    .o_win         (win)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s, c, g;
    logic [1:0] st;
    logic [3:0] lvl;
    logic [1:0] lv;
    logic       rr, win;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [1:0] est, input logic [3:0] elvl,
                     input logic [1:0] elv, input logic err, input logic ewin);
    logic [9:0] got, exp;
    got = {state, level, lives, rr, win};
    exp = {est, elvl, elv, err, ewin};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%b lvl=%0d lives=%0d rr=%b win=%b, want st=%b lvl=%0d lives=%0d rr=%b win=%b",
               name, state, level, lives, rr, win, est, elvl, elv, err, ewin);
    end
  endtask

  task automatic run(input logic s, input logic c, input logic g, input logic [1:0] est,
                     input logic [3:0] elvl, input logic [1:0] elv, input logic err,
                     input logic ewin, input string name);
    start = s; coll = c; goal = g;
    @(posedge clk); #1;
    chk(name, est, elvl, elv, err, ewin);
  endtask

  // Remaining three PAUSE cycles after entry, the resume cycle and one settled cycle.
  task automatic pause_tail(input logic [3:0] lnow, input logic [3:0] lafter, input logic [1:0] lv);
    for (int k = 0; k < 3; k++) run(0, 0, 0, S_PAU, lnow, lv, 0, 0, "pause");
    run(0, 0, 0, S_RUN, lafter, lv, 1, 0, "resume");
    run(0, 0, 0, S_RUN, lafter, lv, 0, 0, "resume_settle");
  endtask

  initial begin
    //          s  c  g  st     lvl lives rr win
    tbl[0]  = '{1, 0, 0, S_IDLE, 1, LV3, 0, 0};  // start held from reset: no game
    tbl[1]  = '{0, 0, 0, S_IDLE, 1, LV3, 0, 0};
    tbl[2]  = '{1, 0, 0, S_RUN,  1, LV3, 1, 0};  // press edge
    tbl[3]  = '{1, 0, 0, S_RUN,  1, LV3, 0, 0};  // pulse lasts one cycle
    tbl[4]  = '{0, 0, 1, S_PAU,  1, LV3, 0, 0};  // goal at level 1
    tbl[5]  = '{0, 0, 0, S_PAU,  1, LV3, 0, 0};
    tbl[6]  = '{1, 0, 0, S_PAU,  1, LV3, 0, 0};  // start ignored in pause
    tbl[7]  = '{0, 0, 0, S_PAU,  1, LV3, 0, 0};
    tbl[8]  = '{0, 0, 0, S_RUN,  2, LV3, 1, 0};  // resume after 4 pause cycles
    tbl[9]  = '{0, 1, 0, S_RUN,  2, LV3, 0, 0};  // collision in round-reset cycle ignored
    tbl[10] = '{1, 0, 0, S_RUN,  2, LV3, 0, 0};  // start ignored while running

    rst = 1; start = 1; coll = 0; goal = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", S_IDLE, 1, LV3, 0, 0);
    rst = 0;

    for (int i = 0; i < 11; i++)
      run(tbl[i].s, tbl[i].c, tbl[i].g, tbl[i].st, tbl[i].lvl, tbl[i].lv, tbl[i].rr, tbl[i].win,
          $sformatf("vec%0d", i));

`ifdef GAME_LIVES_EN
    run(0, 1, 0, S_PAU, 2, 2, 0, 0, "coll1");
    pause_tail(2, 2, 2);
    run(0, 0, 1, S_PAU, 2, 2, 0, 0, "goal_l2");
    pause_tail(2, 3, 2);
    run(0, 1, 1, S_PAU, 3, 1, 0, 0, "coll_and_goal");
    pause_tail(3, 3, 1);
    run(0, 1, 0, S_GO, 3, 0, 0, 0, "last_life");
    run(0, 1, 1, S_GO, 3, 0, 0, 0, "gameover_hold");
    run(1, 0, 0, S_RUN, 1, 3, 1, 0, "restart");
    run(0, 0, 0, S_RUN, 1, 3, 0, 0, "restart_settle");
`else
    run(0, 1, 0, S_GO, 2, 1, 0, 0, "coll_over");
    run(0, 0, 1, S_GO, 2, 1, 0, 0, "gameover_hold");
    run(1, 0, 0, S_RUN, 1, 1, 1, 0, "restart");
    run(0, 0, 0, S_RUN, 1, 1, 0, 0, "restart_settle");
    run(0, 1, 1, S_GO, 1, 1, 0, 0, "coll_beats_goal");
    run(1, 0, 0, S_RUN, 1, 1, 1, 0, "restart2");
    run(0, 0, 0, S_RUN, 1, 1, 0, 0, "restart2_settle");
`endif

    // Climb to the top level.
    for (int l = 1; l < 9; l++) begin
      run(0, 0, 1, S_PAU, 4'(l), LV3, 0, 0, "climb_goal");
      pause_tail(4'(l), 4'(l + 1), LV3);
    end
    run(0, 0, 1, S_GO, 9, LV3, 0, 1, "win");
    run(0, 1, 1, S_GO, 9, LV3, 0, 1, "win_hold");
    run(1, 0, 0, S_RUN, 1, LV3, 1, 0, "win_restart");
    run(0, 0, 0, S_RUN, 1, LV3, 0, 0, "win_restart_settle");

    // Reset in the middle of a pause.
    run(0, 0, 1, S_PAU, 1, LV3, 0, 0, "pre_rst_pause");
    run(0, 0, 0, S_PAU, 1, LV3, 0, 0, "pre_rst_pause2");
    rst = 1;
    run(0, 0, 0, S_IDLE, 1, LV3, 0, 0, "rst_mid_pause");
    run(0, 0, 0, S_IDLE, 1, LV3, 0, 0, "rst_hold");
    rst = 0;
    run(0, 0, 0, S_IDLE, 1, LV3, 0, 0, "post_rst_idle");
    run(1, 0, 0, S_RUN, 1, LV3, 1, 0, "post_rst_start");
    run(0, 0, 0, S_RUN, 1, LV3, 0, 0, "post_rst_settle");
    run(0, 0, 1, S_PAU, 1, LV3, 0, 0, "post_rst_goal");
    pause_tail(1, 2, LV3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
